fc_stage_sequencer: RTL and testbench

- Top-level control FSM for the FC layer accelerator.
- Launches the layer's pipelined sub-stages (input load, MAC loop, bias/activation, output drain) one at a time, in index order, over an ap_ctrl_hs-style start/done handshake.
- Skips stages that are disabled by a per-run mask.
- Runs a per-stage AXI-stream stall watchdog, so that a hung stream is reported as a stall and does not hang the kernel silently.

---
 rtl/fc_stage_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fc_stage_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_stage_sequencer.sv
// fc_stage_sequencer
//   Top-level control FSM for the FC layer accelerator. Launches the layer's
//   sub-stages one at a time, in index order, skipping stages that are not
//   set in the run mask. It also runs a stall watchdog on the active stage's
//   stream-blocked indication.
//
// Handshake (ap_ctrl_hs style):
//   - ap_start is sampled only in IDLE.
//   - A run ends with a one-cycle ap_done/ap_ready pulse.
//   - Toward stage k, stage_start[k] is held high for as long as stage k is
//     active. stage_done[k] is a one-cycle pulse that ends the stage.
//   - There is always at least one cycle with stage_start low between two
//     stages, so every stage sees a fresh rising start.
//
// Ports:
//   ap_clk, ap_rst          clock, synchronous active-high reset
//   ap_start                run request (sampled in IDLE only)
//   ap_done / ap_ready      one-cycle end-of-run pulse
//   ap_idle                 high in IDLE
//   stage_mask              enabled stages, latched on accepted start
//   timeout_limit           stall threshold (0 = watchdog off), latched
//   stage_start             one-hot start to the active stage
//   stage_done              done pulses from the stages
//   stage_blk               per-stage stream-blocked indication
//   clear_stall             leave STALL, return to IDLE
//   cur_stage               index of the active stage
//   stall_flag/stall_stage  STALL indication and the stage that stalled
//   dbg_state               current FSM state, for observation
module fc_stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int IDX_W      = 2,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [NUM_STAGES-1:0] stage_blk,
  input  logic                  clear_stall,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  stall_flag,
  output logic [IDX_W-1:0]      stall_stage,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3,
    S_STALL = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] pending_q, pending_d;
  logic [TIMEOUT_W-1:0]  limit_q, limit_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [IDX_W-1:0]      stall_stage_q, stall_stage_d;

  logic                  cur_done;
  logic                  cur_blk;
  logic [NUM_STAGES-1:0] cur_bit;

  // Index of the lowest set bit; 0 for an empty vector.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_STAGES-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign cur_done = stage_done[cur_q];
  assign cur_blk  = stage_blk[cur_q];
  assign cur_bit  = NUM_STAGES'(1) << cur_q;

  // State register
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      limit_q       <= '0;
      cnt_q         <= '0;
      cur_q         <= '0;
      stall_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      limit_q       <= limit_d;
      cnt_q         <= cnt_d;
      cur_q         <= cur_d;
      stall_stage_q <= stall_stage_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    limit_d       = limit_q;
    cnt_d         = cnt_q;
    cur_d         = cur_q;
    stall_stage_d = stall_stage_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          pending_d = stage_mask;
          limit_d   = timeout_limit;
          cnt_d     = '0;
          if (stage_mask == '0) begin
            state_d = S_DONE;
          end else begin
            cur_d   = lowest_idx(stage_mask);
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // A done in the same cycle as the watchdog expiring takes priority,
        // so the stall check only lives in the not-done branch.
        if (cur_done) begin
          pending_d = pending_q & ~cur_bit;
          cnt_d     = '0;
          state_d   = (pending_d != '0) ? S_GAP : S_DONE;
        end else begin
          if (cur_blk) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);
          end else begin
            cnt_d = '0;
          end
          if ((limit_q != '0) && (cnt_d >= limit_q)) begin
            state_d       = S_STALL;
            stall_stage_d = cur_q;
          end
        end
      end
      S_GAP: begin
        cur_d   = lowest_idx(pending_q);
        state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_STALL: begin
        if (clear_stall) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    stage_start = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_start[i] = (state_q == S_RUN) && (cur_q == IDX_W'(i));
    end
    ap_done     = (state_q == S_DONE);
    ap_ready    = (state_q == S_DONE);
    ap_idle     = (state_q == S_IDLE);
    stall_flag  = (state_q == S_STALL);
    cur_stage   = cur_q;
    stall_stage = stall_stage_q;
    dbg_state   = state_q;
  end

endmodule

// File: tb/tb_fc_stage_sequencer.sv
module tb_fc_stage_sequencer;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_ready;
  logic        ap_idle;
  logic [3:0]  stage_mask;
  logic [15:0] timeout_limit;
  logic [3:0]  stage_start;
  logic [3:0]  stage_done;
  logic [3:0]  stage_blk;
  logic        clear_stall;
  logic [1:0]  cur_stage;
  logic        stall_flag;
  logic [1:0]  stall_stage;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [1:0] exp_q[$];   // expected order of stage launches
  int         lat_a[4];   // cycles from stage_start to stage_done, per stage

  fc_stage_sequencer #(.NUM_STAGES(4), .IDX_W(2), .TIMEOUT_W(16)) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_ready      (ap_ready),
    .ap_idle       (ap_idle),
    .stage_mask    (stage_mask),
    .timeout_limit (timeout_limit),
    .stage_start   (stage_start),
    .stage_done    (stage_done),
    .stage_blk     (stage_blk),
    .clear_stall   (clear_stall),
    .cur_stage     (cur_stage),
    .stall_flag    (stall_flag),
    .stall_stage   (stall_stage),
    .dbg_state     (dbg_state)
  );

  // Clock / reset block
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=hung expected=finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  // Driver + monitor for one run. The caller fills exp_q and lat_a.
  // exp_n is the number of cycles from the accepting edge to the edge after
  // which ap_done (or stall_flag) becomes visible.
  task automatic run_check(input logic [3:0] mask, input logic [15:0] lim,
                           input logic [3:0] blk, input bit gap8,
                           input int exp_n, input bit exp_stall,
                           input logic [1:0] exp_ss);
    int n, c, k;
    bit active, ended;
    logic [3:0] kb;
    @(negedge ap_clk);
    stage_mask    = mask;
    timeout_limit = lim;
    ap_start      = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start      = 1'b0;
    stage_mask    = 4'($urandom);   // latched values must not follow these
    timeout_limit = 16'($urandom_range(1, 3));
    n = 0; c = 0; k = 0; active = 0; ended = 0; kb = '0;
    while (!ended && n < 400) begin
      if (ap_done || stall_flag) begin
        ended = 1;
      end else begin
        if (stage_start != 4'b0) begin
          if (!active) begin
            active = 1;
            c = 1;
            for (int i = 3; i >= 0; i--) if (stage_start[i]) k = i;
            kb = 4'b0001 << k;
            if (exp_q.size() == 0) chk("unexpected_start", k, 4);
            else chk("start_order", k, exp_q.pop_front());
            chk("start_onehot", stage_start, kb);
            chk("cur_stage", cur_stage, k);
          end else begin
            c++;
          end
          stage_done = (4'($urandom) & ~kb) | ((c == lat_a[k]) ? kb : 4'b0);
          stage_blk  = (4'($urandom) & ~kb) |
                       ((blk[k] && !(gap8 && (c % 8 == 0))) ? kb : 4'b0);
        end else begin
          active     = 0;
          stage_done = 4'($urandom);
          stage_blk  = 4'($urandom);
        end
        ap_start = 1'($urandom_range(0, 1));
        @(posedge ap_clk);
        #1;
        n++;
      end
    end
    ap_start   = 1'b0;
    stage_done = 4'b0;
    stage_blk  = 4'b0;
    if (!ended) begin
      chk("run_timeout", 0, 1);
      do_reset();
    end else begin
      chk("end_cycle", n, exp_n);
      chk("stall_flag", stall_flag, exp_stall);
      chk("ap_done", ap_done, !exp_stall);
      chk("ap_ready", ap_ready, !exp_stall);
      chk("ap_idle_busy", ap_idle, 0);
      chk("missing_starts", exp_q.size(), 0);
      if (exp_stall) begin
        chk("stall_stage", stall_stage, exp_ss);
        chk("stall_no_start", stage_start, 0);
        ap_start = 1'b1;   // must be ignored in STALL
        repeat (2) begin
          @(posedge ap_clk);
          #1;
          chk("stall_hold", stall_flag, 1);
          chk("stall_no_done", ap_done, 0);
        end
        ap_start    = 1'b0;
        clear_stall = 1'b1;
        @(posedge ap_clk);
        #1;
        clear_stall = 1'b0;
        chk("clear_idle", ap_idle, 1);
        chk("clear_flag", stall_flag, 0);
      end else begin
        @(posedge ap_clk);
        #1;
        chk("post_done_idle", ap_idle, 1);
        chk("done_one_cycle", ap_done, 0);
      end
    end
    exp_q.delete();
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] lim;
    int          lat;
    logic [3:0]  blk;
    bit          gap8;
    int          exp_n;
    bit          exp_stall;
    logic [1:0]  exp_ss;
    logic [7:0]  ord;     // launch order, 2 bits per entry, first in [1:0]
    int          ord_n;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [3:0]  r_mask, r_blk;
    logic [15:0] r_lim;
    int          ns, n_exp;
    bit          stalled, any, found;
    logic [1:0]  ss;

    tbl[0] = '{4'b1111, 16'd0, 5,  4'b0000, 1'b0, 23, 1'b0, 2'd0, {2'd3, 2'd2, 2'd1, 2'd0}, 4};
    tbl[1] = '{4'b0101, 16'd0, 5,  4'b0000, 1'b0, 11, 1'b0, 2'd0, {2'd0, 2'd0, 2'd2, 2'd0}, 2};
    tbl[2] = '{4'b0000, 16'd0, 5,  4'b0000, 1'b0, 0,  1'b0, 2'd0, 8'd0, 0};
    tbl[3] = '{4'b1111, 16'd8, 20, 4'b0010, 1'b0, 29, 1'b1, 2'd1, {2'd0, 2'd0, 2'd1, 2'd0}, 2};
    tbl[4] = '{4'b0100, 16'd6, 6,  4'b0100, 1'b0, 6,  1'b0, 2'd0, {2'd0, 2'd0, 2'd0, 2'd2}, 1};
    tbl[5] = '{4'b1000, 16'd3, 4,  4'b1000, 1'b0, 3,  1'b1, 2'd3, {2'd0, 2'd0, 2'd0, 2'd3}, 1};
    tbl[6] = '{4'b1010, 16'd0, 1,  4'b1111, 1'b0, 3,  1'b0, 2'd0, {2'd0, 2'd0, 2'd3, 2'd1}, 2};
    tbl[7] = '{4'b0010, 16'd8, 20, 4'b0010, 1'b1, 20, 1'b0, 2'd0, {2'd0, 2'd0, 2'd0, 2'd1}, 1};

    ap_rst = 1'b1; ap_start = 1'b0; stage_mask = '0; timeout_limit = '0;
    stage_done = '0; stage_blk = '0; clear_stall = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_idle", ap_idle, 1);
    chk("rst_start", stage_start, 0);
    chk("rst_done", ap_done, 0);
    chk("rst_ready", ap_ready, 0);
    chk("rst_stall", stall_flag, 0);
    chk("rst_cur", cur_stage, 0);
    chk("rst_sstage", stall_stage, 0);
    ap_rst = 1'b0;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < 4; s++) lat_a[s] = tbl[v].lat;
      for (int s = 0; s < tbl[v].ord_n; s++) exp_q.push_back(tbl[v].ord[2*s +: 2]);
      run_check(tbl[v].mask, tbl[v].lim, tbl[v].blk, tbl[v].gap8,
                tbl[v].exp_n, tbl[v].exp_stall, tbl[v].exp_ss);
    end

    // ap_start held high across an empty-mask run: back-to-back acceptance
    @(negedge ap_clk);
    stage_mask = 4'b0000;
    ap_start   = 1'b1;
    @(posedge ap_clk); #1;
    chk("held_done1", ap_done, 1);
    chk("held_busy1", ap_idle, 0);
    @(posedge ap_clk); #1;
    chk("held_idle", ap_idle, 1);
    chk("held_nodone", ap_done, 0);
    @(posedge ap_clk); #1;
    chk("held_done2", ap_done, 1);
    ap_start = 1'b0;
    @(posedge ap_clk); #1;
    chk("held_idle2", ap_idle, 1);
    @(posedge ap_clk); #1;
    chk("held_quiet", ap_done, 0);

    // Reset in the middle of a run, while stage 2 is active
    @(negedge ap_clk);
    stage_mask    = 4'b1111;
    timeout_limit = 16'd0;
    ap_start      = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (stage_start == 4'b0100) begin
        found = 1;
      end else begin
        stage_done = stage_start;
        @(posedge ap_clk); #1;
      end
    end
    chk("reach_stage2", found, 1);
    stage_done = 4'b0;
    ap_rst     = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    chk("midrst_start", stage_start, 0);
    chk("midrst_idle", ap_idle, 1);
    chk("midrst_cur", cur_stage, 0);
    chk("midrst_done", ap_done, 0);
    for (int s = 0; s < 4; s++) begin
      lat_a[s] = 2;
      exp_q.push_back(2'(s));
    end
    run_check(4'b1111, 16'd0, 4'b0000, 1'b0, 11, 1'b0, 2'd0);

    // Randomized runs against a launch-order / cycle-count model
    for (int r = 0; r < 40; r++) begin
      r_mask = 4'($urandom);
      r_blk  = 4'($urandom);
      r_lim  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 10));
      for (int s = 0; s < 4; s++) lat_a[s] = $urandom_range(1, 12);
      ns = 0; n_exp = 0; stalled = 0; any = 0; ss = 0;
      for (int s = 0; s < 4; s++) begin
        if (r_mask[s] && !stalled) begin
          any = 1;
          exp_q.push_back(2'(s));
          if (r_blk[s] && r_lim != 0 && int'(r_lim) < lat_a[s]) begin
            stalled = 1;
            n_exp   = ns + int'(r_lim);
            ss      = 2'(s);
          end else begin
            ns += lat_a[s] + 1;
          end
        end
      end
      if (!stalled) n_exp = any ? ns - 1 : 0;
      run_check(r_mask, r_lim, r_blk, 1'b0, n_exp, stalled, ss);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
